// File: rtl/pipe_reg_chain_pkg.sv
// pipe_reg_chain_pkg
//   Shared constants for the stage-boundary register chains of the RISC toy
//   core: default NOP payloads per boundary and a sizing helper for the
//   occupancy counter.
package pipe_reg_chain_pkg;

   // D/E control bundle. WEN and DREQ are inactive-high, so a NOP drives them to 1.
   typedef struct packed {
      logic       wen;
      logic       dreq;
      logic [1:0] alu_op;
      logic       br;
      logic       jmp;
   } de_ctrl_t;

   localparam de_ctrl_t    DE_CTRL_NOP = '{wen: 1'b1, dreq: 1'b1, alu_op: 2'b00, br: 1'b0, jmp: 1'b0};
   localparam logic [31:0] FD_INSN_NOP = 32'h0000_0013;
   localparam logic [31:0] EM_DATA_NOP = 32'h0000_0000;

   // Bits needed to count 0..depth valid slots.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_chain_slot.sv
// pipe_reg_chain_slot
//   One valid+data register of the chain. An empty slot always carries NOP_VAL.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over everything)
//   clear      synchronous kill (flush)
//   load       take src_valid/src_data this cycle, otherwise hold
//   src_valid  valid bit of the source (upstream slot or chain input)
//   src_data   payload of the source
//   v, d       registered valid and payload
module pipe_reg_chain_slot
   import pipe_reg_chain_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (clear) begin
         v_d = 1'b0;
         d_d = NOP_VAL;
      end else if (load) begin
         // Loading from an empty source scrubs the payload to NOP.
         v_d = src_valid;
         d_d = src_valid ? src_data : NOP_VAL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= NOP_VAL;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Stallable, flushable stage boundary of DEPTH register slots with
//   valid/ready on both sides. COLLAPSE=1 lets bubbles be squeezed out under
//   a downstream stall; COLLAPSE=0 shifts all slots together.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   FLUSH                synchronous kill of all slots (gates both handshakes)
//   IN_VALID/IN_READY    upstream handshake, IN_DATA payload into slot 0
//   OUT_VALID/OUT_READY  downstream handshake, OUT_DATA from slot DEPTH-1
//   OCC                  number of valid slots
//   STALL_CNT            saturating count of stalled output cycles
module pipe_reg_chain
   import pipe_reg_chain_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 2,
   parameter logic [WIDTH-1:0] NOP_VAL  = {WIDTH{1'b0}},
   parameter bit               COLLAPSE = 1'b1,
   parameter int               CNTW     = 16
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       FLUSH,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [WIDTH-1:0]           IN_DATA,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [WIDTH-1:0]           OUT_DATA,
   output logic [$clog2(DEPTH+1)-1:0] OCC,
   output logic [CNTW-1:0]            STALL_CNT
);

   localparam int             OCCW    = occ_width(DEPTH);
   localparam logic [OCCW:0]  OCC_MAX = (OCCW + 1)'(DEPTH);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];

   logic             in_fire, out_fire;
   logic [OCCW-1:0]  occ_q, occ_d;
   logic [OCCW:0]    occ_sum;
   logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

   // Ready ripples from the output back to slot 0. Without collapsing, every
   // slot sees the last slot's advance so interior bubbles stay put.
   always_comb begin
      logic a;
      a            = ~v[DEPTH-1] | OUT_READY;
      adv          = '0;
      adv[DEPTH-1] = a;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         if (COLLAPSE) a = ~v[i] | a;
         adv[i] = a;
      end
   end

   always_comb begin
      src_v    = '0;
      src_v[0] = IN_VALID;
      src_d[0] = IN_DATA;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = v[i-1];
         src_d[i] = d[i-1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      pipe_reg_chain_slot #(
         .WIDTH   (WIDTH),
         .NOP_VAL (NOP_VAL)
      ) u_slot (
         .clk       (CLK),
         .rst       (RST),
         .clear     (FLUSH),
         .load      (adv[i]),
         .src_valid (src_v[i]),
         .src_data  (src_d[i]),
         .v         (v[i]),
         .d         (d[i])
      );
   end

   assign OUT_DATA  = d[DEPTH-1];
   assign OUT_VALID = v[DEPTH-1] & ~FLUSH;
   assign IN_READY  = adv[0] & ~FLUSH;
   assign in_fire   = IN_VALID & IN_READY;
   assign out_fire  = OUT_VALID & OUT_READY;

   always_comb begin
      occ_sum = {1'b0, occ_q} + (OCCW + 1)'(in_fire);
      if (out_fire) occ_sum = (occ_sum == '0) ? '0 : occ_sum - (OCCW + 1)'(1);
      if (occ_sum > OCC_MAX) occ_sum = OCC_MAX;
      occ_d = FLUSH ? '0 : occ_sum[OCCW-1:0];
   end

   // Flush does not clear the stall history; it only masks counting.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (v[DEPTH-1] & ~OUT_READY & ~FLUSH & (stall_cnt_q != {CNTW{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNTW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         occ_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         occ_q       <= occ_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign OCC       = occ_q;
   assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Four chain configurations share one stimulus stream; a slot-list model
// (sequential compaction / whole-chain shift) predicts every output.
module tb_pipe_reg_chain;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;

   always #5 clk = ~clk;

   // instance 0: D3 collapse, 1: D3 global stall CNTW4, 2: D2 collapse CNTW4, 3: D1
   logic       ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
   logic [7:0] od0, od1, od2, od3;
   logic [1:0] oc0, oc1, oc2;
   logic [0:0] oc3;
   logic [15:0] sc0, sc3;
   logic [3:0]  sc1, sc2;

   pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .NOP_VAL(8'h00), .COLLAPSE(1'b1), .CNTW(16)) u0 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir0), .IN_DATA(in_data),
      .OUT_VALID(ov0), .OUT_READY(out_ready), .OUT_DATA(od0), .OCC(oc0), .STALL_CNT(sc0));
   pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .NOP_VAL(8'h03), .COLLAPSE(1'b0), .CNTW(4)) u1 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir1), .IN_DATA(in_data),
      .OUT_VALID(ov1), .OUT_READY(out_ready), .OUT_DATA(od1), .OCC(oc1), .STALL_CNT(sc1));
   pipe_reg_chain #(.WIDTH(8), .DEPTH(2), .NOP_VAL(8'h03), .COLLAPSE(1'b1), .CNTW(4)) u2 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir2), .IN_DATA(in_data),
      .OUT_VALID(ov2), .OUT_READY(out_ready), .OUT_DATA(od2), .OCC(oc2), .STALL_CNT(sc2));
   pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .NOP_VAL(8'hFF), .COLLAPSE(1'b1), .CNTW(16)) u3 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir3), .IN_DATA(in_data),
      .OUT_VALID(ov3), .OUT_READY(out_ready), .OUT_DATA(od3), .OCC(oc3), .STALL_CNT(sc3));

   logic        ir_a [4];
   logic        ov_a [4];
   logic [7:0]  od_a [4];
   logic [15:0] oc_a [4];
   logic [15:0] sc_a [4];

   always_comb begin
      ir_a[0] = ir0; ir_a[1] = ir1; ir_a[2] = ir2; ir_a[3] = ir3;
      ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2; ov_a[3] = ov3;
      od_a[0] = od0; od_a[1] = od1; od_a[2] = od2; od_a[3] = od3;
      oc_a[0] = {14'b0, oc0}; oc_a[1] = {14'b0, oc1}; oc_a[2] = {14'b0, oc2}; oc_a[3] = {15'b0, oc3};
      sc_a[0] = sc0; sc_a[1] = {12'b0, sc1}; sc_a[2] = {12'b0, sc2}; sc_a[3] = sc3;
   end

   int         DEP  [4] = '{3, 3, 2, 1};
   bit         COL  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] NOPV [4] = '{8'h00, 8'h03, 8'h03, 8'hFF};
   int         CW   [4] = '{16, 4, 4, 16};

   bit         m_v [4][3];
   logic [7:0] m_d [4][3];
   int         m_stall [4];

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Combinational view: what the outputs must be given model state and current inputs.
   function automatic void model_comb(input int k, output bit ir_e, output bit ov_e,
                                      output logic [7:0] od_e, output int occ_e);
      int n;
      bit vv [3];
      bit free0;
      n = DEP[k];
      occ_e = 0;
      for (int i = 0; i < 3; i++) vv[i] = m_v[k][i];
      for (int i = 0; i < n; i++) if (m_v[k][i]) occ_e++;
      if (COL[k]) begin
         if (vv[n-1] && out_ready) vv[n-1] = 1'b0;
         for (int i = n - 2; i >= 0; i--)
            if (vv[i] && !vv[i+1]) begin vv[i+1] = 1'b1; vv[i] = 1'b0; end
         free0 = !vv[0];
      end else begin
         free0 = !m_v[k][n-1] || out_ready;
      end
      ir_e = free0 && !flush;
      ov_e = m_v[k][n-1] && !flush;
      od_e = m_d[k][n-1];
   endfunction

   task automatic model_update();
      for (int k = 0; k < 4; k++) begin
         int n;
         int smax;
         n    = DEP[k];
         smax = (1 << CW[k]) - 1;
         if (rst) begin
            for (int i = 0; i < n; i++) begin m_v[k][i] = 1'b0; m_d[k][i] = NOPV[k]; end
            m_stall[k] = 0;
         end else begin
            if (m_v[k][n-1] && !out_ready && !flush && m_stall[k] < smax) m_stall[k]++;
            if (flush) begin
               for (int i = 0; i < n; i++) begin m_v[k][i] = 1'b0; m_d[k][i] = NOPV[k]; end
            end else if (COL[k]) begin
               if (m_v[k][n-1] && out_ready) begin m_v[k][n-1] = 1'b0; m_d[k][n-1] = NOPV[k]; end
               for (int i = n - 2; i >= 0; i--)
                  if (m_v[k][i] && !m_v[k][i+1]) begin
                     m_v[k][i+1] = 1'b1; m_d[k][i+1] = m_d[k][i];
                     m_v[k][i]   = 1'b0; m_d[k][i]   = NOPV[k];
                  end
               if (!m_v[k][0]) begin
                  m_v[k][0] = in_valid;
                  m_d[k][0] = in_valid ? in_data : NOPV[k];
               end
            end else if (!m_v[k][n-1] || out_ready) begin
               for (int i = n - 1; i >= 1; i--) begin m_v[k][i] = m_v[k][i-1]; m_d[k][i] = m_d[k][i-1]; end
               m_v[k][0] = in_valid;
               m_d[k][0] = in_valid ? in_data : NOPV[k];
            end
         end
      end
   endtask

   always @(posedge clk) model_update();

   always @(negedge clk) begin
      bit         ire, ove;
      logic [7:0] ode;
      int         occe;
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            model_comb(k, ire, ove, ode, occe);
            check("in_ready",  k, 16'(ir_a[k]), 16'(ire));
            check("out_valid", k, 16'(ov_a[k]), 16'(ove));
            check("out_data",  k, 16'(od_a[k]), 16'(ode));
            check("occ_popcount", k, oc_a[k], 16'(occe));
            check("stall_cnt", k, sc_a[k], 16'(m_stall[k]));
         end
      end
   end

   task automatic set_in(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic fl, input logic rs);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   initial begin
      int bias;
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick(2);
      chk_en = 1'b1;

      // streaming through DEPTH=3
      do_reset();
      set_in(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
      check("s1_ready_empty", 0, 16'(ir_a[0]), 16'h1);
      tick();
      set_in(1'b1, 8'h11, 1'b1, 1'b0, 1'b0); tick();
      set_in(1'b1, 8'h12, 1'b1, 1'b0, 1'b0); tick();
      set_in(1'b1, 8'h13, 1'b1, 1'b0, 1'b0);
      check("s1_first_out", 0, 16'(od_a[0]), 16'h10);
      check("s1_occ_full",  0, oc_a[0], 16'h3);
      check("s1_ready_full", 0, 16'(ir_a[0]), 16'h1);
      tick();
      set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("s1_second_out", 0, 16'(od_a[0]), 16'h11);
      check("s1_occ_hold",   0, oc_a[0], 16'h3);
      tick();
      check("s1_third_out", 0, 16'(od_a[0]), 16'h12);
      tick(3);

      // bubble: collapse vs global stall
      do_reset();
      set_in(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("s2_col_occ",   0, oc_a[0], 16'h2);
      check("s2_col_ready", 0, 16'(ir_a[0]), 16'h1);
      check("s2_gs_ready",  1, 16'(ir_a[1]), 16'h0);
      check("s2_gs_occ",    1, oc_a[1], 16'h2);
      check("s2_gs_head",   1, 16'(od_a[1]), 16'h0A);
      tick();
      check("s2_gs_head_hold", 1, 16'(od_a[1]), 16'h0A);
      set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick(4);

      // back-pressure, DEPTH=2
      do_reset();
      set_in(1'b1, 8'h01, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 8'h02, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      check("s3_ready_full", 2, 16'(ir_a[2]), 16'h0);
      tick(5);
      check("s3_stall5", 2, sc_a[2], 16'h5);
      check("s3_head",   2, 16'(od_a[2]), 16'h01);
      set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("s3_drain1", 2, 16'(od_a[2]), 16'h01);
      tick();
      check("s3_drain2", 2, 16'(od_a[2]), 16'h02);
      check("s3_drain2_v", 2, 16'(ov_a[2]), 16'h1);
      tick();
      check("s3_empty_v",   2, 16'(ov_a[2]), 16'h0);
      check("s3_empty_nop", 2, 16'(od_a[2]), 16'h03);
      check("s3_stall_kept", 2, sc_a[2], 16'h5);

      // flush with a simultaneous input
      do_reset();
      set_in(1'b1, 8'h05, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 8'h06, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
      check("s4_stall1", 2, sc_a[2], 16'h1);
      set_in(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
      check("s4_flush_ov", 2, 16'(ov_a[2]), 16'h0);
      check("s4_flush_ir", 2, 16'(ir_a[2]), 16'h0);
      tick();
      set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("s4_occ0",  2, oc_a[2], 16'h0);
      check("s4_nop",   2, 16'(od_a[2]), 16'h03);
      check("s4_stall_not_cleared", 2, sc_a[2], 16'h1);
      tick(2);
      check("s4_no_7", 2, 16'(ov_a[2]), 16'h0);

      // reset beats flush
      do_reset();
      set_in(1'b1, 8'h55, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick(10);
      check("s5_stall9", 2, sc_a[2], 16'h9);
      set_in(1'b1, 8'h77, 1'b0, 1'b1, 1'b1); tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("s5_stall0", 2, sc_a[2], 16'h0);
      check("s5_nop",    2, 16'(od_a[2]), 16'h03);
      check("s5_occ0",   2, oc_a[2], 16'h0);

      // saturation at CNTW=4
      do_reset();
      set_in(1'b1, 8'h21, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick(25);
      check("s6_sat", 1, sc_a[1], 16'hF);
      tick(3);
      check("s6_sat_hold", 1, sc_a[1], 16'hF);

      // random traffic with varying back-pressure
      bias = 2;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) bias = int'($urandom_range(0, 4));
         set_in(1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 4) >= bias),
                1'($urandom_range(0, 24) == 0),
                1'($urandom_range(0, 299) == 0));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
